gray_ptr_sync: RTL



---
 rtl/gray_ptr_sync.sv | 100 ++++++++++
 1 files changed

// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync: carries a Gray-coded FIFO pointer from another clock domain
// through a STAGES-deep synchroniser chain, decodes it to binary and reports
// the per-cycle advance (ptr_delta / ptr_changed).
// Optional single-bit-change checker: define GRAY_PTR_SYNC_CHECK_EN to build
// prev_gray, the popcount compare, gray_err and err_sticky. Without the macro
// both flags are tied low and err_clr is ignored.
module gray_ptr_sync #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ptr_gray_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] ptr_gray_sync,
  output logic [WIDTH-1:0] ptr_bin,
  output logic [WIDTH-1:0] ptr_delta,
  output logic             ptr_changed,
  output logic             gray_err,
  output logic             err_sticky
);

  if (WIDTH < 2 || WIDTH > 16 || STAGES < 2 || STAGES > 4) begin : g_param_check
    $error("gray_ptr_sync: WIDTH must be 2..16 and STAGES must be 2..4");
  end

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] ptr_bin_q;
  logic [WIDTH-1:0] ptr_delta_q;
  logic             changed_q;

  // Synchroniser chain; stage 0 is the only flop that sees the async input.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= ptr_gray_in;
      for (int k = 1; k < STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign ptr_gray_sync = sync_q[STAGES-1];

  // Gray to binary: each binary bit is the parity of the Gray bits at and above it.
  always_comb begin
    bin_d = '0;
    for (int i = 0; i < WIDTH; i++) bin_d[i] = ^(ptr_gray_sync >> i);
  end

  // Decode stage: new binary value and modular advance since the last cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_bin_q   <= '0;
      ptr_delta_q <= '0;
      changed_q   <= 1'b0;
    end else begin
      ptr_bin_q   <= bin_d;
      ptr_delta_q <= bin_d - ptr_bin_q;
      changed_q   <= (bin_d != ptr_bin_q);
    end
  end

  assign ptr_bin     = ptr_bin_q;
  assign ptr_delta   = ptr_delta_q;
  assign ptr_changed = changed_q;

`ifdef GRAY_PTR_SYNC_CHECK_EN
  logic [WIDTH-1:0] prev_gray_q;
  logic             viol;
  logic             gray_err_q;
  logic             err_sticky_q;

  // More than one bit flipping between consecutive synchronised values
  // means the source launched a non-Gray update (or coalesced steps).
  assign viol = ($countones(ptr_gray_sync ^ prev_gray_q) > 1);

  // Checker state; a new violation outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_gray_q  <= '0;
      gray_err_q   <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      prev_gray_q  <= ptr_gray_sync;
      gray_err_q   <= viol;
      err_sticky_q <= viol | (err_sticky_q & ~err_clr);
    end
  end

  assign gray_err   = gray_err_q;
  assign err_sticky = err_sticky_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign gray_err       = 1'b0;
  assign err_sticky     = 1'b0;
`endif

endmodule
